// File: rtl/heatmap_bank_arbiter.sv
// Arbitrates the single heat-map column memory port between the HPS point writer
// (one-hot select, level ack) and the VGA scan reader (request / one-cycle ack).
module heatmap_bank_arbiter #(
    parameter int COLS        = 100,
    parameter int ROWS        = 480,
    parameter int WR_MAX_WAIT = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [COLS-1:0]     wr_col_select,
    input  logic [9:0]          wr_row,
    input  logic signed [7:0]   wr_data,
    output logic [COLS-1:0]     wr_return,
    input  logic                rd_req,
    input  logic [6:0]          rd_col,
    input  logic [9:0]          rd_row,
    output logic                rd_ack,
    output logic signed [7:0]   rd_data,
    output logic [6:0]          mem_col,
    output logic [9:0]          mem_row,
    output logic                mem_we,
    output logic signed [7:0]   mem_wdata,
    input  logic signed [7:0]   mem_rdata,
    output logic                busy,
    output logic                err_multi,
    output logic                err_range
);

    localparam int CW = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_ACK,
        S_RD_WAIT,
        S_RD_CAP,
        S_RD_DONE
    } state_t;

    function automatic logic [CW-1:0] lowest_idx(input logic [COLS-1:0] sel);
        logic [CW-1:0] idx;
        idx = '0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (sel[i]) idx = CW'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_grant_rd;
    logic                  w_grant_wr;
    logic                  w_wr_pend;
    logic                  w_wr_multi;
    logic [CW-1:0]         w_wr_idx;
    logic                  w_wr_row_ok;
    logic                  w_rd_oor;
    logic                  w_starved;

    logic [3:0]            r_starve;
    logic [CW-1:0]         r_wr_idx;
    logic                  r_rd_oor;
    logic [COLS-1:0]       r_wr_return;
    logic                  r_rd_ack;
    logic signed [7:0]     r_rd_data;
    logic [CW-1:0]         r_mem_col;
    logic [9:0]            r_mem_row;
    logic                  r_mem_we;
    logic signed [7:0]     r_mem_wdata;
    logic                  r_err_multi;
    logic                  r_err_range;

    assign w_wr_pend   = |wr_col_select;
    assign w_wr_multi  = (wr_col_select & (wr_col_select - COLS'(1))) != '0;
    assign w_wr_idx    = lowest_idx(wr_col_select);
    assign w_wr_row_ok = wr_row < 10'(ROWS);
    assign w_rd_oor    = (rd_col >= CW'(COLS)) || (rd_row >= 10'(ROWS));
    assign w_starved   = r_starve == 4'(WR_MAX_WAIT);

    // The reader wins ties unless the writer has already waited out its quota.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_rd  = 1'b0;
        w_grant_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rd_req && !(w_wr_pend && w_starved)) begin
                    w_grant_rd  = 1'b1;
                    w_state_nxt = S_RD_WAIT;
                end else if (w_wr_pend) begin
                    w_grant_wr  = 1'b1;
                    w_state_nxt = S_WR;
                end
            end
            S_WR:      w_state_nxt = S_WR_ACK;
            S_WR_ACK:  if (!wr_col_select[r_wr_idx]) w_state_nxt = S_IDLE;
            S_RD_WAIT: w_state_nxt = S_RD_CAP;
            S_RD_CAP:  w_state_nxt = S_RD_DONE;
            S_RD_DONE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (!w_wr_pend || w_grant_wr) begin
            r_starve <= '0;
        end else if (w_grant_rd) begin
            r_starve <= sat_inc4(r_starve);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_idx    <= '0;
            r_rd_oor    <= 1'b0;
            r_wr_return <= '0;
            r_rd_ack    <= 1'b0;
            r_rd_data   <= '0;
            r_mem_col   <= '0;
            r_mem_row   <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_err_multi <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_rd) begin
                        r_mem_col <= rd_col;
                        r_mem_row <= rd_row;
                        r_mem_we  <= 1'b0;
                        r_rd_oor  <= w_rd_oor;
                    end else if (w_grant_wr) begin
                        r_wr_idx    <= w_wr_idx;
                        r_mem_col   <= w_wr_idx;
                        r_mem_row   <= wr_row;
                        r_mem_wdata <= wr_data;
                        r_mem_we    <= w_wr_row_ok;
                        if (!w_wr_row_ok) r_err_range <= 1'b1;
                        if (w_wr_multi)   r_err_multi <= 1'b1;
                    end
                end
                S_WR: begin
                    r_mem_we    <= 1'b0;
                    r_wr_return <= COLS'(1) << r_wr_idx;
                end
                S_WR_ACK: begin
                    if (!wr_col_select[r_wr_idx]) r_wr_return <= '0;
                end
                // Memory output lands two edges after the address was registered.
                S_RD_CAP: begin
                    r_rd_data <= r_rd_oor ? 8'sd0 : mem_rdata;
                    r_rd_ack  <= 1'b1;
                    if (r_rd_oor) r_err_range <= 1'b1;
                end
                S_RD_DONE: begin
                    r_rd_ack <= 1'b0;
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign wr_return = r_wr_return;
    assign rd_ack    = r_rd_ack;
    assign rd_data   = r_rd_data;
    assign mem_col   = r_mem_col;
    assign mem_row   = r_mem_row;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_state != S_IDLE;
    assign err_multi = r_err_multi;
    assign err_range = r_err_range;

endmodule

// File: tb/tb_heatmap_bank_arbiter.sv
// Bench for heatmap_bank_arbiter: directed cases plus randomized serial traffic
// checked against a shadow copy of the heat-map contents.
`define CHK(t, o, e) chk(t, 128'(o), 128'(e))

module tb_heatmap_bank_arbiter;

    localparam int COLS        = 100;
    localparam int ROWS        = 480;
    localparam int WR_MAX_WAIT = 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [COLS-1:0]   wr_col_select;
    logic [9:0]        wr_row;
    logic [7:0]        wr_data;
    logic [COLS-1:0]   wr_return;
    logic              rd_req;
    logic [6:0]        rd_col;
    logic [9:0]        rd_row;
    logic              rd_ack;
    logic [7:0]        rd_data;
    logic [6:0]        mem_col;
    logic [9:0]        mem_row;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              busy;
    logic              err_multi;
    logic              err_range;

    heatmap_bank_arbiter #(
        .COLS(COLS), .ROWS(ROWS), .WR_MAX_WAIT(WR_MAX_WAIT)
    ) dut (
        .clock(clock), .reset(reset),
        .wr_col_select(wr_col_select), .wr_row(wr_row), .wr_data(wr_data),
        .wr_return(wr_return),
        .rd_req(rd_req), .rd_col(rd_col), .rd_row(rd_row),
        .rd_ack(rd_ack), .rd_data(rd_data),
        .mem_col(mem_col), .mem_row(mem_row), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err_multi(err_multi), .err_range(err_range)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    // Synchronous-read column store; out-of-range addresses return a nonzero pattern.
    logic [7:0] mem [0:COLS*ROWS-1];
    logic       mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < COLS * ROWS; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we && int'(mem_col) < COLS && int'(mem_row) < ROWS)
                mem[int'(mem_col) * ROWS + int'(mem_row)] <= mem_wdata;
            if (int'(mem_col) < COLS && int'(mem_row) < ROWS)
                mem_rdata <= mem[int'(mem_col) * ROWS + int'(mem_row)];
            else
                mem_rdata <= 8'h5A;
        end
    end

    logic [7:0] ref_mem [0:COLS*ROWS-1];
    bit   exp_em, exp_er;
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        `CHK({tag, "_ret"},   wr_return, 0);
        `CHK({tag, "_ack"},   rd_ack, 0);
        `CHK({tag, "_rdata"}, rd_data, 0);
        `CHK({tag, "_mcol"},  mem_col, 0);
        `CHK({tag, "_mrow"},  mem_row, 0);
        `CHK({tag, "_mwe"},   mem_we, 0);
        `CHK({tag, "_mwd"},   mem_wdata, 0);
        `CHK({tag, "_busy"},  busy, 0);
        `CHK({tag, "_emul"},  err_multi, 0);
        `CHK({tag, "_erng"},  err_range, 0);
    endtask

    task automatic do_write(input logic [COLS-1:0] sel, input int row,
                            input logic [7:0] data, input int hold);
        int col;
        logic [COLS-1:0] oh;
        col = -1;
        for (int i = 0; i < COLS; i++) if (sel[i] && col < 0) col = i;
        oh = '0;
        oh[col] = 1'b1;
        wr_col_select = sel;
        wr_row        = 10'(row);
        wr_data       = data;
        tick();
        `CHK("wr_busy",  busy, 1);
        `CHK("wr_we",    mem_we, (row < ROWS));
        `CHK("wr_col",   mem_col, col);
        `CHK("wr_row",   mem_row, row);
        `CHK("wr_wdata", mem_wdata, data);
        `CHK("wr_ret0",  wr_return, 0);
        wr_row  = ~wr_row;
        wr_data = ~data;
        tick();
        `CHK("wr_we_off", mem_we, 0);
        `CHK("wr_ret",    wr_return, oh);
        if (row < ROWS) ref_mem[col * ROWS + row] = data;
        else            exp_er = 1'b1;
        if ($countones(sel) > 1) exp_em = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            `CHK("wr_ret_hold", wr_return, oh);
        end
        wr_col_select = '0;
        tick();
        `CHK("wr_ret_drop", wr_return, 0);
        `CHK("wr_idle",     busy, 0);
        `CHK("wr_emul",     err_multi, exp_em);
        `CHK("wr_erng",     err_range, exp_er);
    endtask

    task automatic do_read(input int col, input int row);
        bit         oor;
        logic [7:0] expv;
        oor  = (col >= COLS) || (row >= ROWS);
        expv = oor ? 8'h00 : ref_mem[col * ROWS + row];
        rd_req = 1'b1;
        rd_col = 7'(col);
        rd_row = 10'(row);
        tick();
        `CHK("rd_busy", busy, 1);
        `CHK("rd_mcol", mem_col, col);
        `CHK("rd_mrow", mem_row, row);
        `CHK("rd_mwe",  mem_we, 0);
        `CHK("rd_ack0", rd_ack, 0);
        rd_col = ~rd_col;
        rd_row = ~rd_row;
        tick();
        `CHK("rd_ack1", rd_ack, 0);
        tick();
        `CHK("rd_ack",  rd_ack, 1);
        `CHK("rd_data", rd_data, expv);
        rd_req = 1'b0;
        if (oor) exp_er = 1'b1;
        tick();
        `CHK("rd_ack_off", rd_ack, 0);
        `CHK("rd_idle",    busy, 0);
        `CHK("rd_erng",    err_range, exp_er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [COLS-1:0] sel;
        int acks, acks_before, acks_after, cyc, col, row;
        bit wdone;
        int wq[$];

        for (int i = 0; i < COLS * ROWS; i++) ref_mem[i] = init_val(i);
        exp_em = 1'b0;
        exp_er = 1'b0;
        reset = 1'b0;
        wr_col_select = '0; wr_row = '0; wr_data = '0;
        rd_req = 1'b0; rd_col = '0; rd_row = '0;
        repeat (3) tick();
        chk_all_zero("rst");
        reset = 1'b1;
        tick();

        sel = '0; sel[37] = 1'b1;
        do_write(sel, 200, 8'h7F, 2);
        sel = '0; sel[5] = 1'b1;
        do_write(sel, 10, 8'hA3, 0);
        do_read(5, 10);
        do_read(37, 200);

        sel = '0; sel[3] = 1'b1; sel[60] = 1'b1;
        do_write(sel, 7, 8'h55, 1);
        do_read(3, 7);
        do_read(60, 7);
        sel = '0; sel[12] = 1'b1;
        do_write(sel, 8, 8'hC4, 0);

        sel = '0; sel[20] = 1'b1;
        do_write(sel, 480, 8'h99, 1);
        do_read(20, 479);
        do_read(100, 10);
        do_read(4, 480);

        // Reader hammering while a write waits: the writer must get in after the quota.
        sel = '0; sel[17] = 1'b1;
        wr_col_select = sel; wr_row = 10'd33; wr_data = 8'h42;
        rd_req = 1'b1; rd_col = 7'd9; rd_row = 10'd21;
        acks = 0; acks_before = -1; acks_after = 0; cyc = 0; wdone = 1'b0;
        while (cyc < 400 && !(wdone && acks_after >= 3)) begin
            tick();
            cyc++;
            if (rd_ack) begin
                n_chk++;
                if (rd_data === ref_mem[9 * ROWS + 21]) n_pass++;
                else $error("FAIL cont_rdata: observed 0x%0h expected 0x%0h",
                            rd_data, ref_mem[9 * ROWS + 21]);
                if (wdone) acks_after++;
                else       acks++;
                if (wdone && acks_after >= 3) rd_req = 1'b0;
            end
            if (mem_we) begin
                acks_before = acks;
                ref_mem[17 * ROWS + 33] = 8'h42;
            end
            if (wr_return[17] && wr_col_select != '0) begin
                wr_col_select = '0;
                wdone = 1'b1;
            end
        end
        rd_req = 1'b0;
        wr_col_select = '0;
        n_chk++;
        if (acks_before === WR_MAX_WAIT) n_pass++;
        else $error("FAIL starve_reads: observed %0d expected %0d", acks_before, WR_MAX_WAIT);
        n_chk++;
        if (wdone === 1'b1 && acks_after >= 3) n_pass++;
        else $error("FAIL reads_resume: wdone %0d acks_after %0d", wdone, acks_after);
        repeat (6) tick();
        `CHK("cont_idle", busy, 0);
        do_read(17, 33);

        // Reset while the writer is waiting for its select to drop.
        sel = '0; sel[44] = 1'b1;
        wr_col_select = sel; wr_row = 10'd100; wr_data = 8'h11;
        tick();
        tick();
        `CHK("mid_ret", wr_return[44], 1);
        ref_mem[44 * ROWS + 100] = 8'h11;
        reset = 1'b0;
        tick();
        chk_all_zero("midrst");
        wr_col_select = '0;
        reset = 1'b1;
        exp_em = 1'b0;
        exp_er = 1'b0;
        tick();
        `CHK("post_rst_busy", busy, 0);
        do_read(44, 100);

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(1) == 1) begin
                col = int'($urandom_range(COLS - 1));
                sel = '0;
                sel[col] = 1'b1;
                if (col < COLS - 1 && $urandom_range(5) == 0)
                    sel[$urandom_range(COLS - 1, col + 1)] = 1'b1;
                row = ($urandom_range(9) == 0) ? int'($urandom_range(1023, ROWS))
                                               : int'($urandom_range(ROWS - 1));
                do_write(sel, row, 8'($urandom), int'($urandom_range(3)));
                if (row < ROWS) wq.push_back(col * ROWS + row);
            end else if (wq.size() > 0 && $urandom_range(1) == 1) begin
                row = wq[$urandom_range(wq.size() - 1)];
                do_read(row / ROWS, row % ROWS);
            end else begin
                col = ($urandom_range(7) == 0) ? int'($urandom_range(127, COLS))
                                               : int'($urandom_range(COLS - 1));
                row = ($urandom_range(7) == 0) ? int'($urandom_range(1023, ROWS))
                                               : int'($urandom_range(ROWS - 1));
                do_read(col, row);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/heatmap_bank_arbiter.md
# heatmap_bank_arbiter

- Shares the single port of the heat-map column memory between two requesters:
  - the point writer, which uses a one-hot column select, row index and level handshake;
  - the VGA scan reader, which uses request/ack.
- Sits between the HPS point writer and the M10K column store, and in front of the VGA pixel pipeline.
- Reader has priority; a starvation counter guarantees writer progress.
- Also decodes the one-hot column select, range-checks coordinates and keeps sticky error flags.

## Interface
Parameters:
- COLS, 100, number of columns (width of one-hot select/return buses)
- ROWS, 480, valid rows per column
- WR_MAX_WAIT, 8, consecutive read grants allowed while a write is pending

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low (reset==0 clears state on the next posedge)
- wr_col_select  in  COLS  one-hot write request, held until matching wr_return seen
- wr_row  in  10  write row index
- wr_data  in  8  signed heat value
- wr_return  out  COLS  level ack, bit matches served column
- rd_req  in  1  read request, held until rd_ack
- rd_col  in  7  read column index
- rd_row  in  10  read row index
- rd_ack  out  1  one-cycle pulse, rd_data valid same cycle
- rd_data  out  8  read value
- mem_col  out  7  memory column address
- mem_row  out  10  memory row address
- mem_we  out  1  memory write strobe, one cycle
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, sampled 2 edges after address is driven
- busy  out  1  state != IDLE
- err_multi  out  1  sticky: more than one wr_col_select bit set
- err_range  out  1  sticky: write with wr_row >= ROWS, or read with rd_col >= COLS or rd_row >= ROWS

## Operation
- Write request: wr_col_select != 0.
  - Index = lowest set bit.
  - If two or more bits are set, set err_multi and still serve the lowest bit.
- States and transitions:
  - IDLE, read chosen: register mem_col/mem_row from rd_col/rd_row, mem_we=0 -> RD_WAIT.
  - IDLE, write chosen: register mem_col=index, mem_row=wr_row, mem_wdata=wr_data; mem_we=1 if wr_row < ROWS, else mem_we=0 and set err_range -> WR.
  - WR: mem_we<=0; wr_return[index]<=1 -> WR_ACK.
  - WR_ACK: stay while wr_col_select[index]==1; when it drops, wr_return<=0 -> IDLE.
  - RD_WAIT -> RD_CAP.
  - RD_CAP: rd_data<=mem_rdata (0 and set err_range if request out of range); rd_ack<=1 -> RD_DONE.
  - RD_DONE: rd_ack<=0 -> IDLE.
- Arbitration in IDLE:
  - Only rd_req: read. Only a write request: write.
  - Both requests present: read wins unless starve_cnt == WR_MAX_WAIT, in which case write wins.
- starve_cnt (4 bits, saturating):
  - +1 on each read grant while a write request is pending;
  - cleared on every write grant;
  - cleared when no write is pending.
- Index and row are latched at grant; changes to the inputs during service are ignored.
- Errors are cleared only by reset.

## Timing
- Reset values: all outputs 0 (wr_return=0, rd_ack=0, rd_data=0, mem_*=0, busy=0, err_*=0); state IDLE; starve_cnt=0.
- Reset mid-transaction aborts it and drops wr_return/rd_ack; requesters must re-request.
- Write, request sampled at edge t:
  - mem_we high in cycle t+1 to t+2;
  - wr_return high from edge t+2;
  - IDLE one edge after the select bit is seen low.
- Read, rd_req sampled at edge t: rd_ack and rd_data visible for one cycle after edge t+3. Back-to-back reads are serviced every 4 cycles.
- A writer that polls return on alternate cycles cannot miss the ack, because wr_return is a level.
- A request arriving while busy waits; nothing is queued beyond the held request lines.

## Test plan
- Single write, col_select bit 37, row 200, data 0x7F -> mem_we pulse, mem_col=37, mem_row=200, mem_wdata=0x7F; wr_return[37]=1 until the select drops, then 0.
- Read col 5, row 10, memory model returning 0xA3 -> rd_ack one cycle at t+3, rd_data=0xA3.
- rd_req held continuously plus a pending write, WR_MAX_WAIT=8 -> exactly 8 reads, then the write is granted, then reads resume.
- col_select bits 3 and 60 set -> column 3 written, err_multi=1 and stays 1.
- Write with row 480 -> no mem_we, wr_return still given, err_range=1.
- Read out of range (col 100 or row >= 480) -> rd_data=0, rd_ack still pulses, err_range=1.
- reset=0 asserted during WR_ACK -> next cycle all outputs 0, state IDLE.
